// File: rtl/alu_scheduler.sv
// ---------------------------------------------------------------------------
// alu_scheduler
//
// Shares one combinational ALU between two requesters. Each requester has a
// valid/ready request channel and a valid/ready response channel. A
// round-robin arbiter picks one request in IDLE. The operands are registered
// and drive the ALU for one EXEC cycle. The result and flags are then
// captured and held in RESP until the owning requester consumes them.
// Only one operation is in flight at a time.
//
// Ports
//   i_clk, i_reset_n             clock (rising edge), async active-low reset
//   i_reqN_valid / o_reqN_ready  request handshake, N = 0,1
//   i_reqN_a, i_reqN_b, i_reqN_op operands and ALUControl code of requester N
//   o_rspN_valid / i_rspN_ready  response handshake, N = 0,1
//   o_rsp_result, o_rsp_flags    held result / NZCV flags (shared)
//   o_alu_a, o_alu_b, o_alu_ctrl registered operands to the ALU
//   i_alu_result, i_alu_flags    combinational ALU outputs
// ---------------------------------------------------------------------------
module alu_scheduler (
    input  logic        i_clk,
    input  logic        i_reset_n,

    input  logic        i_req0_valid,
    output logic        o_req0_ready,
    input  logic [31:0] i_req0_a,
    input  logic [31:0] i_req0_b,
    input  logic [1:0]  i_req0_op,

    input  logic        i_req1_valid,
    output logic        o_req1_ready,
    input  logic [31:0] i_req1_a,
    input  logic [31:0] i_req1_b,
    input  logic [1:0]  i_req1_op,

    output logic        o_rsp0_valid,
    input  logic        i_rsp0_ready,
    output logic        o_rsp1_valid,
    input  logic        i_rsp1_ready,

    output logic [31:0] o_rsp_result,
    output logic [3:0]  o_rsp_flags,

    output logic [31:0] o_alu_a,
    output logic [31:0] o_alu_b,
    output logic [1:0]  o_alu_ctrl,
    input  logic [31:0] i_alu_result,
    input  logic [3:0]  i_alu_flags
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_op_a;
    logic [31:0] r_op_b;
    logic [1:0]  r_op_ctrl;
    logic        r_owner;
    logic        r_last_grant;
    logic [31:0] r_res;
    logic [3:0]  r_flg;
    logic        r_rsp0_valid;
    logic        r_rsp1_valid;

    logic        w_idle;
    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_rsp_done;

    assign w_idle = (r_state == ST_IDLE);

    // A sole valid requester wins outright. When both are valid, the one
    // that was not granted last time wins. last_grant resets to 1, so req0
    // wins the first contested arbitration.
    assign w_gnt0 = w_idle & i_req0_valid & (~i_req1_valid |  r_last_grant);
    assign w_gnt1 = w_idle & i_req1_valid & (~i_req0_valid | ~r_last_grant);

    // Only the owner's ready ends the response. The other ready is ignored.
    assign w_rsp_done = r_owner ? i_rsp1_ready : i_rsp0_ready;

    assign o_req0_ready = w_gnt0;
    assign o_req1_ready = w_gnt1;
    assign o_rsp0_valid = r_rsp0_valid;
    assign o_rsp1_valid = r_rsp1_valid;
    assign o_rsp_result = r_res;
    assign o_rsp_flags  = r_flg;
    assign o_alu_a      = r_op_a;
    assign o_alu_b      = r_op_b;
    assign o_alu_ctrl   = r_op_ctrl;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= ST_IDLE;
            r_op_a       <= 32'd0;
            r_op_b       <= 32'd0;
            r_op_ctrl    <= 2'b00;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_res        <= 32'd0;
            r_flg        <= 4'd0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt0) begin
                        r_op_a       <= i_req0_a;
                        r_op_b       <= i_req0_b;
                        r_op_ctrl    <= i_req0_op;
                        r_owner      <= 1'b0;
                        r_last_grant <= 1'b0;
                        r_state      <= ST_EXEC;
                    end else if (w_gnt1) begin
                        r_op_a       <= i_req1_a;
                        r_op_b       <= i_req1_b;
                        r_op_ctrl    <= i_req1_op;
                        r_owner      <= 1'b1;
                        r_last_grant <= 1'b1;
                        r_state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // The ALU has seen the registered operands for one full
                    // cycle. Capture its outputs here and raise the owner's
                    // response valid.
                    r_res        <= i_alu_result;
                    r_flg        <= i_alu_flags;
                    r_rsp0_valid <= ~r_owner;
                    r_rsp1_valid <=  r_owner;
                    r_state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (w_rsp_done) begin
                        r_rsp0_valid <= 1'b0;
                        r_rsp1_valid <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
